game_tick_scheduler: RTL and testbench

- Converts the 100 MHz system clock into single-cycle enable strobes for the snake game: pixel enable, input-debounce tick, and a game-move tick whose rate depends on the speed level.
- Runs a run/pause/stop state machine that gates the move tick.
- Downstream logic stays on clk and qualifies its work with these strobes.

---
 rtl/game_tick_scheduler.sv | 148 ++++++++++++++
 tb/tb_game_tick_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - enable-strobe generator and run/pause/stop FSM for the snake game
//
// Purpose:
//   Derives single-cycle enables from the system clock. Downstream logic stays
//   on clk and qualifies its work with these strobes:
//     - pix_en    : every PIX_DIV cycles
//     - deb_tick  : every DEB_DIV cycles
//     - move_tick : at the speed-level dependent move rate, only in RUN
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous reset, active-low
//   run_req    in   pulse: start from IDLE or resume from PAUSE
//   pause_req  in   pulse: RUN -> PAUSE
//   stop_req   in   pulse: any state -> IDLE
//   level_load in   pulse: capture level_in as the pending level
//   level_in   in   [2:0] requested speed level
//   pix_en     out  pixel enable strobe
//   deb_tick   out  debounce strobe
//   move_tick  out  game move strobe
//   state      out  [1:0] 00 IDLE, 01 RUN, 10 PAUSE
//   level_out  out  [2:0] level currently applied to the move divisor

module game_tick_scheduler #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int DEB_HZ   = 100,
  parameter int DEB_DIV  = CLK_HZ / DEB_HZ,
  parameter int PIX_DIV  = 4,
  parameter int BASE_DIV = 27_000_000,
  parameter int STEP_DIV = 2_500_000,
  parameter int MIN_DIV  = 8_000_000,
  parameter int DIV_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_req,
  input  logic       pause_req,
  input  logic       stop_req,
  input  logic       level_load,
  input  logic [2:0] level_in,
  output logic       pix_en,
  output logic       deb_tick,
  output logic       move_tick,
  output logic [1:0] state,
  output logic [2:0] level_out
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DEB_LAST = DIV_W'(DEB_DIV - 1);
  localparam logic [DIV_W-1:0] BASE_V   = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] STEP_V   = DIV_W'(STEP_DIV);
  localparam logic [DIV_W-1:0] MIN_V    = DIV_W'(MIN_DIV);
  // How far the divisor may drop below BASE_DIV before the floor takes over.
  localparam logic [DIV_W-1:0] HEADROOM = DIV_W'(BASE_DIV - MIN_DIV);

  logic [PIX_W-1:0] pix_cnt;
  logic [DIV_W-1:0] deb_cnt;
  logic [DIV_W-1:0] move_cnt;
  logic [DIV_W-1:0] step_total;
  logic [DIV_W-1:0] div;
  logic [2:0]       pending;
  logic             pend_valid;
  logic [1:0]       state_nxt;
  logic             pix_hit;
  logic             deb_hit;
  logic             move_hit;
  logic             apply_level;

  // Compare against the headroom first so the subtraction can never wrap.
  assign step_total = DIV_W'(level_out) * STEP_V;
  assign div        = (step_total >= HEADROOM) ? MIN_V : (BASE_V - step_total);

  assign pix_hit  = (pix_cnt == PIX_LAST);
  assign deb_hit  = (deb_cnt == DEB_LAST);
  // >= rather than ==: a level change while paused can shrink the divisor
  // below the frozen count, which must end the interval instead of wrapping.
  assign move_hit = (state == S_RUN) && (move_cnt >= div - DIV_W'(1));

  // Strobes are masked during the reset cycle so a terminal count that lands
  // on reset never escapes.
  assign pix_en    = rst_n & pix_hit;
  assign deb_tick  = rst_n & deb_hit;
  assign move_tick = rst_n & move_hit;

  // A pending level waits for an interval boundary while running.
  assign apply_level = pend_valid && ((state != S_RUN) || move_hit);

  always_comb begin
    state_nxt = state;
    if (stop_req) begin
      state_nxt = S_IDLE;
    end else if (pause_req && (state == S_RUN)) begin
      state_nxt = S_PAUSE;
    end else if (run_req && (state != S_RUN)) begin
      state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      deb_cnt <= '0;
    end else begin
      pix_cnt <= pix_hit ? '0 : pix_cnt + PIX_W'(1);
      deb_cnt <= deb_hit ? '0 : deb_cnt + DIV_W'(1);
    end
  end

  // The count advances in every RUN cycle, including the one carrying
  // pause_req, so a resume continues exactly where counting stopped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      move_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stop_req) begin
        move_cnt <= '0;
      end else if (state == S_RUN) begin
        move_cnt <= move_hit ? '0 : move_cnt + DIV_W'(1);
      end
    end
  end

  // A load in the same cycle as an application keeps the newer value pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_out  <= 3'd0;
      pending    <= 3'd0;
      pend_valid <= 1'b0;
    end else begin
      if (apply_level) begin
        level_out  <= pending;
        pend_valid <= 1'b0;
      end
      if (level_load) begin
        pending    <= level_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - self-checking bench for game_tick_scheduler
module tb_game_tick_scheduler;

  localparam int PIX  = 4;
  localparam int DEB  = 10;
  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MINV = 8;

  logic       clk = 1'b0;
  logic       rst_n, run_req, pause_req, stop_req, level_load;
  logic [2:0] level_in;
  logic       pix_en, deb_tick, move_tick;
  logic [1:0] state;
  logic [2:0] level_out;

  int tests = 0;
  int fails = 0;

  game_tick_scheduler #(
    .DEB_DIV (DEB),
    .PIX_DIV (PIX),
    .BASE_DIV(BASE),
    .STEP_DIV(STEP),
    .MIN_DIV (MINV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_req   (run_req),
    .pause_req (pause_req),
    .stop_req  (stop_req),
    .level_load(level_load),
    .level_in  (level_in),
    .pix_en    (pix_en),
    .deb_tick  (deb_tick),
    .move_tick (move_tick),
    .state     (state),
    .level_out (level_out)
  );

  always #5 clk = ~clk;

  // Reference model: game mode, elapsed cycles in the current move interval,
  // applied/pending level and cycles since reset release.
  int m_mode;      // 0 idle, 1 run, 2 pause
  int m_elapsed;
  int m_level;
  int m_pend;
  bit m_pend_v;
  int m_age;
  bit m_valid = 1'b0;

  int cyc_no = 0;
  int ticks[$];

  function automatic int move_period(input int lvl);
    int d;
    d = BASE - lvl * STEP;
    return (d < MINV) ? MINV : d;
  endfunction

  function automatic bit tick_due();
    return (m_mode == 1) && (m_elapsed + 1 >= move_period(m_level));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic run, input logic pause,
                     input logic stop, input logic load, input logic [2:0] lvl);
    bit e_pix, e_deb, e_move;
    rst_n = r; run_req = run; pause_req = pause; stop_req = stop;
    level_load = load; level_in = lvl;
    #3;
    e_pix  = r && m_valid && (m_age % PIX == 0);
    e_deb  = r && m_valid && (m_age % DEB == 0);
    e_move = r && m_valid && tick_due();
    if (m_valid || !r) begin
      chk("pix_en", int'(pix_en), int'(e_pix));
      chk("deb_tick", int'(deb_tick), int'(e_deb));
      chk("move_tick", int'(move_tick), int'(e_move));
    end
    if (m_valid) begin
      chk("state", int'(state), m_mode);
      chk("level_out", int'(level_out), m_level);
    end
    if (move_tick === 1'b1) ticks.push_back(cyc_no);
    @(posedge clk);
    if (!r) begin
      m_mode = 0; m_elapsed = 0; m_level = 0; m_pend = 0; m_pend_v = 0;
      m_age = 1; m_valid = 1'b1;
    end else if (m_valid) begin
      m_age++;
      if (m_pend_v && (m_mode != 1 || e_move)) begin
        m_level = m_pend; m_pend_v = 0;
      end
      if (load) begin
        m_pend = int'(lvl); m_pend_v = 1;
      end
      if (m_mode == 1) m_elapsed = e_move ? 0 : m_elapsed + 1;
      if (stop) begin
        m_mode = 0; m_elapsed = 0;
      end else if (pause && m_mode == 1) begin
        m_mode = 2;
      end else if (run && m_mode != 1) begin
        m_mode = 1;
      end
    end
    cyc_no++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 3'd0);
  endtask

  function automatic int tick_rel(input int k, input int base);
    return (ticks.size() > k) ? ticks[k] - base : -1;
  endfunction

  int c0;
  bit hit;

  initial begin
    // 1: reset then free-running strobes in IDLE
    cyc(0, 0, 0, 0, 0, 3'd0);
    cyc(0, 0, 0, 0, 0, 3'd0);
    ticks.delete();
    idle(40);
    chk("idle_no_move", ticks.size(), 0);

    // 2: level 0 run
    c0 = cyc_no; ticks.delete();
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(60);
    chk("run_t1", tick_rel(0, c0), 20);
    chk("run_t2", tick_rel(1, c0), 40);
    chk("run_t3", tick_rel(2, c0), 60);

    // 3: level change while running waits for the interval boundary
    cyc(1, 0, 0, 1, 1, 3'd0);
    idle(2);
    c0 = cyc_no; ticks.delete();
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(4);
    cyc(1, 0, 0, 0, 1, 3'd2);
    idle(45);
    chk("lvl2_t1", tick_rel(0, c0), 20);
    chk("lvl2_t2", tick_rel(1, c0), 32);
    chk("lvl2_t3", tick_rel(2, c0), 44);

    // 3b: level 7 clamps to the floor divisor
    cyc(1, 0, 0, 1, 1, 3'd7);
    idle(2);
    c0 = cyc_no; ticks.delete();
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(20);
    chk("lvl7_t1", tick_rel(0, c0), 8);
    chk("lvl7_t2", tick_rel(1, c0), 16);

    // 4: pause and resume keep the phase
    cyc(1, 0, 0, 1, 1, 3'd0);
    idle(2);
    c0 = cyc_no; ticks.delete();
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(14);
    cyc(1, 0, 1, 0, 0, 3'd0);
    idle(14);
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(10);
    chk("resume_t1", tick_rel(0, c0), 35);

    // 5: pause+stop on the terminal count
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (tick_due()) begin
        hit = 1;
        c0 = cyc_no; ticks.delete();
        cyc(1, 0, 1, 1, 0, 3'd0);
      end else begin
        cyc(1, 0, 0, 0, 0, 3'd0);
      end
    end
    chk("term_reached", int'(hit), 1);
    chk("term_tick", tick_rel(0, c0), 0);
    chk("term_state", int'(state), 0);
    c0 = cyc_no; ticks.delete();
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(22);
    chk("restart_t1", tick_rel(0, c0), 20);

    // 6: reset mid-run at level 3
    cyc(1, 0, 0, 1, 1, 3'd3);
    idle(2);
    cyc(1, 1, 0, 0, 0, 3'd0);
    idle(9);
    cyc(0, 0, 0, 0, 0, 3'd0);
    chk("rst_state", int'(state), 0);
    chk("rst_level", int'(level_out), 0);
    idle(10);

    // random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 19) == 0),
          3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
